// File: rtl/vmul_seq_if.sv
// Issue and writeback bundle for the sequenced vector multiplier.
// The slave modport faces the multiplier. The master modport faces the issue stage and writeback.
interface vmul_seq_if #(
  parameter int unsigned SOFT_THREAD = 8,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned WID_W       = 3,
  parameter int unsigned IDX_W       = 8
);
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [SOFT_THREAD*XLEN-1:0]   in1_i;
  logic [SOFT_THREAD*XLEN-1:0]   in2_i;
  logic [SOFT_THREAD*XLEN-1:0]   in3_i;
  logic [SOFT_THREAD-1:0]        mask_i;
  logic [5:0]                    ctrl_alu_fn_i;
  logic                          ctrl_reverse_i;
  logic [WID_W-1:0]              ctrl_wid_i;
  logic [IDX_W-1:0]              ctrl_reg_idxw_i;
  logic                          ctrl_wvd_i;
  logic                          ctrl_wxd_i;

  logic                          outx_valid_o;
  logic                          outx_ready_i;
  logic [XLEN-1:0]               outx_wb_wxd_rd_o;
  logic                          outx_wxd_o;
  logic [IDX_W-1:0]              outx_reg_idwx_o;
  logic [WID_W-1:0]              outx_warp_id_o;

  logic                          outv_valid_o;
  logic                          outv_ready_i;
  logic [SOFT_THREAD*XLEN-1:0]   outv_wb_wxd_rd_o;
  logic [SOFT_THREAD-1:0]        outv_wvd_mask_o;
  logic                          outv_wvd_o;
  logic [IDX_W-1:0]              outv_reg_idxw_o;
  logic [WID_W-1:0]              outv_warp_id_o;

  modport slave (
    input  in_valid_i, in1_i, in2_i, in3_i, mask_i, ctrl_alu_fn_i, ctrl_reverse_i,
           ctrl_wid_i, ctrl_reg_idxw_i, ctrl_wvd_i, ctrl_wxd_i, outx_ready_i, outv_ready_i,
    output in_ready_o, outx_valid_o, outx_wb_wxd_rd_o, outx_wxd_o, outx_reg_idwx_o,
           outx_warp_id_o, outv_valid_o, outv_wb_wxd_rd_o, outv_wvd_mask_o, outv_wvd_o,
           outv_reg_idxw_o, outv_warp_id_o
  );

  modport master (
    output in_valid_i, in1_i, in2_i, in3_i, mask_i, ctrl_alu_fn_i, ctrl_reverse_i,
           ctrl_wid_i, ctrl_reg_idxw_i, ctrl_wvd_i, ctrl_wxd_i, outx_ready_i, outv_ready_i,
    input  in_ready_o, outx_valid_o, outx_wb_wxd_rd_o, outx_wxd_o, outx_reg_idwx_o,
           outx_warp_id_o, outv_valid_o, outv_wb_wxd_rd_o, outv_wvd_mask_o, outv_wvd_o,
           outv_reg_idxw_o, outv_warp_id_o
  );
endinterface

// File: rtl/vmul_seq.sv
// Sequenced vector multiplier: SOFT_THREAD lanes run as HARD_THREAD-wide passes through a
// MUL_STAGES-deep pipeline. Passes with no active lanes are skipped.
module vmul_seq #(
  parameter int unsigned SOFT_THREAD = 8,
  parameter int unsigned HARD_THREAD = 4,
  parameter int unsigned MUL_STAGES  = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned WID_W       = 3,
  parameter int unsigned IDX_W       = 8
) (
  input logic       clk,
  input logic       rst_n,
  vmul_seq_if.slave io
);
  localparam int unsigned NPASS = (SOFT_THREAD + HARD_THREAD - 1) / HARD_THREAD;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_e;
  typedef logic [XLEN-1:0] word_t;

  state_e state_q, state_d;
  logic   accept, issue, drain_done, fire;

  word_t            in_a [NPASS][HARD_THREAD];
  word_t            in_b [NPASS][HARD_THREAD];
  word_t            in_c [NPASS][HARD_THREAD];
  logic             in_m [NPASS][HARD_THREAD];
  logic [NPASS-1:0] in_act;

  word_t                  a_q [NPASS][HARD_THREAD];
  word_t                  b_q [NPASS][HARD_THREAD];
  word_t                  c_q [NPASS][HARD_THREAD];
  logic                   m_q [NPASS][HARD_THREAD];
  logic [NPASS-1:0]       act_q, issue_oh;
  logic [2:0]             fn_q;
  logic                   wxd_q, wvd_q;
  logic [WID_W-1:0]       wid_q;
  logic [IDX_W-1:0]       idx_q;
  logic [SOFT_THREAD-1:0] mask_q;

  word_t                 sa, sb, sc;
  logic                  sm;
  word_t                 lane_res [HARD_THREAD];
  logic [MUL_STAGES-1:0] vld_q;
  logic [NPASS-1:0]      poh_q [MUL_STAGES];
  word_t                 pd_q  [MUL_STAGES][HARD_THREAD];
  word_t                 res_q [NPASS][HARD_THREAD];
  logic [SOFT_THREAD*XLEN-1:0] res_flat;

  logic unused_fn;
  assign unused_fn = ^io.ctrl_alu_fn_i[5:3];

  function automatic word_t mul_op(input logic [2:0] fn, input word_t a, input word_t b,
                                   input word_t c);
    logic [2*XLEN-1:0] ax, bx, prod;
    logic              as, bs;
    as   = (fn == 3'd1) || (fn == 3'd2);
    bs   = (fn == 3'd1);
    ax   = {{XLEN{as & a[XLEN-1]}}, a};
    bx   = {{XLEN{bs & b[XLEN-1]}}, b};
    prod = ax * bx;
    case (fn)
      3'd1, 3'd2, 3'd3: return prod[2*XLEN-1:XLEN];
      3'd4:             return prod[XLEN-1:0] + c;
      3'd5:             return c - prod[XLEN-1:0];
      default:          return prod[XLEN-1:0];
    endcase
  endfunction

  // Regroup the flat lane vectors by pass. Padding lanes stay zero and inactive.
  // A scalar op keeps only lane 0, so it is always exactly one pass.
  always_comb begin
    for (int unsigned p = 0; p < NPASS; p++) begin
      for (int unsigned h = 0; h < HARD_THREAD; h++) begin
        in_a[p][h] = '0;
        in_b[p][h] = '0;
        in_c[p][h] = '0;
        in_m[p][h] = 1'b0;
      end
    end
    for (int unsigned l = 0; l < SOFT_THREAD; l++) begin
      in_a[l/HARD_THREAD][l%HARD_THREAD] = io.ctrl_reverse_i ? io.in2_i[l*XLEN +: XLEN]
                                                             : io.in1_i[l*XLEN +: XLEN];
      in_b[l/HARD_THREAD][l%HARD_THREAD] = io.ctrl_reverse_i ? io.in1_i[l*XLEN +: XLEN]
                                                             : io.in2_i[l*XLEN +: XLEN];
      in_c[l/HARD_THREAD][l%HARD_THREAD] = io.in3_i[l*XLEN +: XLEN];
      in_m[l/HARD_THREAD][l%HARD_THREAD] = io.mask_i[l];
    end
    if (io.ctrl_wxd_i) begin
      for (int unsigned p = 0; p < NPASS; p++)
        for (int unsigned h = 0; h < HARD_THREAD; h++) in_m[p][h] = 1'b0;
      in_m[0][0] = 1'b1;
    end
    in_act = '0;
    for (int unsigned p = 0; p < NPASS; p++)
      for (int unsigned h = 0; h < HARD_THREAD; h++) in_act[p] = in_act[p] | in_m[p][h];
  end

  assign accept   = io.in_valid_i & io.in_ready_o;
  assign issue    = (state_q == S_ISSUE);
  assign issue_oh = act_q & (~act_q + NPASS'(1));
  assign fire     = wxd_q ? io.outx_ready_i : io.outv_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= '0;
      fn_q   <= '0;
      wxd_q  <= 1'b0;
      wvd_q  <= 1'b0;
      wid_q  <= '0;
      idx_q  <= '0;
      mask_q <= '0;
      for (int unsigned p = 0; p < NPASS; p++) begin
        for (int unsigned h = 0; h < HARD_THREAD; h++) begin
          a_q[p][h] <= '0;
          b_q[p][h] <= '0;
          c_q[p][h] <= '0;
          m_q[p][h] <= 1'b0;
        end
      end
    end else if (accept) begin
      act_q  <= in_act;
      fn_q   <= io.ctrl_alu_fn_i[2:0];
      wxd_q  <= io.ctrl_wxd_i;
      wvd_q  <= io.ctrl_wvd_i;
      wid_q  <= io.ctrl_wid_i;
      idx_q  <= io.ctrl_reg_idxw_i;
      mask_q <= io.mask_i;
      a_q    <= in_a;
      b_q    <= in_b;
      c_q    <= in_c;
      m_q    <= in_m;
    end else if (issue) begin
      act_q <= act_q & ~issue_oh;
    end
  end

  always_comb begin
    sa = '0;
    sb = '0;
    sc = '0;
    sm = 1'b0;
    for (int unsigned h = 0; h < HARD_THREAD; h++) begin
      sa = '0;
      sb = '0;
      sc = '0;
      sm = 1'b0;
      for (int unsigned p = 0; p < NPASS; p++) begin
        if (issue_oh[p]) begin
          sa = a_q[p][h];
          sb = b_q[p][h];
          sc = c_q[p][h];
          sm = m_q[p][h];
        end
      end
      lane_res[h] = sm ? mul_op(fn_q, sa, sb, sc) : '0;
    end
  end

  // Each pass carries its one-hot pass index so that its results land in the right buffer slice on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned s = 0; s < MUL_STAGES; s++) begin
        poh_q[s] <= '0;
        for (int unsigned h = 0; h < HARD_THREAD; h++) pd_q[s][h] <= '0;
      end
    end else begin
      vld_q[0] <= issue;
      poh_q[0] <= issue_oh;
      pd_q[0]  <= lane_res;
      for (int unsigned s = 1; s < MUL_STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        poh_q[s] <= poh_q[s-1];
        pd_q[s]  <= pd_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < NPASS; p++)
        for (int unsigned h = 0; h < HARD_THREAD; h++) res_q[p][h] <= '0;
    end else if (accept) begin
      for (int unsigned p = 0; p < NPASS; p++)
        for (int unsigned h = 0; h < HARD_THREAD; h++) res_q[p][h] <= '0;
    end else if (vld_q[MUL_STAGES-1]) begin
      for (int unsigned p = 0; p < NPASS; p++)
        if (poh_q[MUL_STAGES-1][p]) res_q[p] <= pd_q[MUL_STAGES-1];
    end
  end

  // Passes are issued back-to-back, so the last pass is exiting once every earlier stage is empty.
  always_comb begin
    drain_done = 1'b1;
    for (int unsigned s = 0; s + 1 < MUL_STAGES; s++)
      if (vld_q[s]) drain_done = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_act == '0) state_d = io.ctrl_wvd_i ? S_OUT : S_IDLE;
          else              state_d = S_ISSUE;
        end
      end
      S_ISSUE: if ((act_q & ~issue_oh) == '0) state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = (wxd_q | wvd_q) ? S_OUT : S_IDLE;
      S_OUT:   if (fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    io.in_ready_o   = rst_n & (state_q == S_IDLE);
    io.outx_valid_o = (state_q == S_OUT) & wxd_q;
    io.outv_valid_o = (state_q == S_OUT) & ~wxd_q & wvd_q;
  end

  always_comb begin
    res_flat = '0;
    for (int unsigned l = 0; l < SOFT_THREAD; l++)
      res_flat[l*XLEN +: XLEN] = res_q[l/HARD_THREAD][l%HARD_THREAD];
  end

  assign io.outx_wb_wxd_rd_o = res_q[0][0];
  assign io.outx_wxd_o       = wxd_q;
  assign io.outx_reg_idwx_o  = idx_q;
  assign io.outx_warp_id_o   = wid_q;
  assign io.outv_wb_wxd_rd_o = res_flat;
  assign io.outv_wvd_mask_o  = mask_q;
  assign io.outv_wvd_o       = wvd_q;
  assign io.outv_reg_idxw_o  = idx_q;
  assign io.outv_warp_id_o   = wid_q;
endmodule

// File: tb/tb_vmul_seq.sv
// Randomised and directed bench for vmul_seq with SOFT_THREAD=8, HARD_THREAD=4, MUL_STAGES=2, XLEN=32.
// Expected results come from a lane-wise arithmetic model of the multiply operations.
module tb_vmul_seq;
  localparam int ST = 8;
  localparam int HT = 4;
  localparam int MS = 2;
  localparam int XL = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  vmul_seq_if #(.SOFT_THREAD(ST), .XLEN(XL), .WID_W(3), .IDX_W(8)) vif ();

  vmul_seq #(
    .SOFT_THREAD(ST), .HARD_THREAD(HT), .MUL_STAGES(MS), .XLEN(XL), .WID_W(3), .IDX_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (vif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] op_a [8];
  logic [31:0] op_b [8];
  logic [31:0] op_c [8];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] fn, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
    longint     sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (fn)
      3'd1:    p = sa * sb;
      3'd2:    p = sa * longint'(b);
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    case (fn)
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:             return p[31:0] + c;
      3'd5:             return c - p[31:0];
      default:          return p[31:0];
    endcase
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    for (int i = 0; i < 8; i++) begin
      op_a[i] = a;
      op_b[i] = b;
      op_c[i] = c;
    end
  endtask

  task automatic run_op(input logic [2:0] fn, input logic [7:0] mask, input logic wxd,
                        input logic wvd, input logic rev, input int hold);
    logic [255:0] ev;
    logic [2:0]   wid;
    logic [7:0]   idx;
    int           ni, lat, seen, k;
    logic         oth, vout;
    wid = 3'($urandom);
    idx = 8'($urandom);
    ev  = '0;
    for (int i = 0; i < 8; i++)
      if (wxd ? (i == 0) : mask[i]) ev[i*32 +: 32] = ref_op(fn, op_a[i], op_b[i], op_c[i]);
    ni = wxd ? 1 : (int'(mask[3:0] != 4'h0) + int'(mask[7:4] != 4'h0));

    @(negedge clk);
    vif.in_valid_i      = 1'b1;
    vif.ctrl_alu_fn_i   = {3'($urandom), fn};
    vif.ctrl_reverse_i  = rev;
    vif.ctrl_wid_i      = wid;
    vif.ctrl_reg_idxw_i = idx;
    vif.ctrl_wxd_i      = wxd;
    vif.ctrl_wvd_i      = wvd;
    vif.mask_i          = mask;
    for (int i = 0; i < 8; i++) begin
      vif.in1_i[i*32 +: 32] = rev ? op_b[i] : op_a[i];
      vif.in2_i[i*32 +: 32] = rev ? op_a[i] : op_b[i];
      vif.in3_i[i*32 +: 32] = op_c[i];
    end
    check("ready_idle", 256'(vif.in_ready_o), 256'(1));
    @(posedge clk);
    #1;
    vif.in_valid_i = 1'b0;
    vif.in1_i      = {8{$urandom}};
    vif.in2_i      = {8{$urandom}};
    vif.in3_i      = {8{$urandom}};
    vif.mask_i     = 8'($urandom);

    if (!wxd && !wvd) begin
      lat = (ni == 0) ? 0 : ni + MS;
      oth = 1'b0;
      k   = 0;
      while (!vif.in_ready_o && k < 20) begin
        oth = oth | vif.outx_valid_o | vif.outv_valid_o;
        @(posedge clk);
        #1;
        k++;
      end
      oth = oth | vif.outx_valid_o | vif.outv_valid_o;
      check("silent_ready_cycle", 256'(k), 256'(lat));
      check("silent_no_valid", 256'(oth), 256'(0));
      return;
    end

    lat  = (ni == 0) ? 1 : ni + MS;
    seen = -1;
    oth  = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      vout = wxd ? vif.outx_valid_o : vif.outv_valid_o;
      oth  = oth | (wxd ? vif.outv_valid_o : vif.outx_valid_o);
      if (vout) begin
        seen = k;
        break;
      end
    end
    check("latency", 256'(seen), 256'(lat));
    if (seen < 0) return;

    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(posedge clk);
        #1;
      end
      if (wxd) begin
        check("x_valid", 256'(vif.outx_valid_o), 256'(1));
        check("x_data", 256'(vif.outx_wb_wxd_rd_o), 256'(ev[31:0]));
        check("x_tags", 256'({vif.outx_wxd_o, vif.outx_reg_idwx_o, vif.outx_warp_id_o}),
              256'({1'b1, idx, wid}));
        oth = oth | vif.outv_valid_o;
      end else begin
        check("v_valid", 256'(vif.outv_valid_o), 256'(1));
        check("v_data", vif.outv_wb_wxd_rd_o, ev);
        check("v_tags", 256'({vif.outv_wvd_o, vif.outv_reg_idxw_o, vif.outv_warp_id_o,
                              vif.outv_wvd_mask_o}), 256'({1'b1, idx, wid, mask}));
        oth = oth | vif.outx_valid_o;
      end
      check("busy_not_ready", 256'(vif.in_ready_o), 256'(0));
    end
    check("other_port_quiet", 256'(oth), 256'(0));

    @(negedge clk);
    if (wxd) vif.outx_ready_i = 1'b1;
    else     vif.outv_ready_i = 1'b1;
    @(posedge clk);
    #1;
    vif.outx_ready_i = 1'b0;
    vif.outv_ready_i = 1'b0;
    check("done_ready", 256'(vif.in_ready_o), 256'(1));
    check("done_valid", 256'(vif.outx_valid_o | vif.outv_valid_o), 256'(0));
  endtask

  initial begin
    logic       oth;
    logic [7:0] m;
    logic       wxd, wvd;
    int         r;
    vif.in_valid_i      = 1'b0;
    vif.in1_i           = '0;
    vif.in2_i           = '0;
    vif.in3_i           = '0;
    vif.mask_i          = '0;
    vif.ctrl_alu_fn_i   = '0;
    vif.ctrl_reverse_i  = 1'b0;
    vif.ctrl_wid_i      = '0;
    vif.ctrl_reg_idxw_i = '0;
    vif.ctrl_wvd_i      = 1'b0;
    vif.ctrl_wxd_i      = 1'b0;
    vif.outx_ready_i    = 1'b0;
    vif.outv_ready_i    = 1'b0;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 256'(vif.in_ready_o), 256'(0));
    check("rst_valids", 256'({vif.outx_valid_o, vif.outv_valid_o}), 256'(0));
    check("rst_vdata", vif.outv_wb_wxd_rd_o, 256'(0));
    check("rst_xdata", 256'(vif.outx_wb_wxd_rd_o), 256'(0));
    check("rst_tags", 256'({vif.outv_wvd_mask_o, vif.outv_wvd_o, vif.outx_wxd_o,
                            vif.outx_reg_idwx_o, vif.outv_warp_id_o}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 256'(vif.in_ready_o), 256'(1));

    // Vector MUL over both passes.
    for (int i = 0; i < 8; i++) begin
      op_a[i] = 32'(i);
      op_b[i] = 32'd3;
      op_c[i] = 32'd0;
    end
    run_op(3'd0, 8'hFF, 1'b0, 1'b1, 1'b0, 0);
    check("mul_lane7", 256'(vif.outv_wb_wxd_rd_o[255:224]), 256'(21));
    check("mul_lane1", 256'(vif.outv_wb_wxd_rd_o[63:32]), 256'(3));

    // MACC with only the low pass active.
    set_ops(32'd2, 32'd5, 32'd1);
    run_op(3'd4, 8'h0F, 1'b0, 1'b1, 1'b0, 0);
    check("macc_lane0", 256'(vif.outv_wb_wxd_rd_o[31:0]), 256'(11));
    check("macc_lane4", 256'(vif.outv_wb_wxd_rd_o[159:128]), 256'(0));

    // High-half products and operand reversal.
    set_ops(32'hFFFF_FFFF, 32'd2, 32'd0);
    run_op(3'd1, 8'h01, 1'b0, 1'b1, 1'b0, 0);
    check("mulh", 256'(vif.outv_wb_wxd_rd_o[31:0]), 256'(32'hFFFF_FFFF));
    run_op(3'd2, 8'h01, 1'b0, 1'b1, 1'b0, 0);
    check("mulhsu", 256'(vif.outv_wb_wxd_rd_o[31:0]), 256'(32'hFFFF_FFFF));
    run_op(3'd3, 8'h01, 1'b0, 1'b1, 1'b0, 0);
    check("mulhu", 256'(vif.outv_wb_wxd_rd_o[31:0]), 256'(32'h1));
    run_op(3'd0, 8'hFF, 1'b0, 1'b1, 1'b1, 0);
    check("mul_rev", 256'(vif.outv_wb_wxd_rd_o[31:0]), 256'(32'hFFFF_FFFE));

    // Scalar NMSAC ignores the mask and takes priority over the vector port.
    set_ops(32'd3, 32'd4, 32'd10);
    run_op(3'd5, 8'hA0, 1'b1, 1'b1, 1'b0, 0);
    check("nmsac_x", 256'(vif.outx_wb_wxd_rd_o), 256'(32'hFFFF_FFFE));

    run_op(3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    check("zero_mask_data", vif.outv_wb_wxd_rd_o, 256'(0));
    run_op(3'd0, 8'h0F, 1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      op_a[i] = rnd_word();
      op_b[i] = rnd_word();
      op_c[i] = rnd_word();
    end
    run_op(3'd4, 8'hFF, 1'b0, 1'b1, 1'b0, 5);

    // Reset while the second pass is still waiting to issue.
    @(negedge clk);
    vif.in_valid_i = 1'b1;
    vif.mask_i     = 8'hFF;
    vif.ctrl_wvd_i = 1'b1;
    vif.ctrl_wxd_i = 1'b0;
    @(posedge clk);
    #1;
    vif.in_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 256'(vif.in_ready_o), 256'(0));
    check("midrst_valids", 256'({vif.outx_valid_o, vif.outv_valid_o}), 256'(0));
    check("midrst_vdata", vif.outv_wb_wxd_rd_o, 256'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    oth   = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      oth = oth | vif.outx_valid_o | vif.outv_valid_o;
    end
    check("midrst_no_stale_valid", 256'(oth), 256'(0));
    check("midrst_ready_back", 256'(vif.in_ready_o), 256'(1));
    for (int i = 0; i < 8; i++) begin
      op_a[i] = $urandom;
      op_b[i] = $urandom;
      op_c[i] = $urandom;
    end
    run_op(3'd0, 8'hFF, 1'b0, 1'b1, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) begin
        op_a[i] = rnd_word();
        op_b[i] = rnd_word();
        op_c[i] = rnd_word();
      end
      case ($urandom_range(0, 5))
        0:       m = 8'h00;
        1:       m = 8'h0F;
        2:       m = 8'hF0;
        default: m = 8'($urandom);
      endcase
      r = $urandom_range(0, 5);
      wxd = (r == 0);
      wvd = (r == 0) ? 1'($urandom) : (r != 1);
      run_op(3'($urandom), m, wxd, wvd, 1'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vmul_seq.md
# vmul_seq

Sequenced vector multiplier that executes a SOFT_THREAD-lane integer multiply/multiply-accumulate on HARD_THREAD physical multiplier lanes. Passes are issued one per cycle through a MUL_STAGES-deep multiplier pipeline, and passes with no active lanes are skipped. It sits in the SM execute pipeline beside the ALU and FPU and uses the same issue-side control fields. Results return on either the scalar (wxd) or the vector (wvd) writeback port through a one-entry output register.

## Interface
- SOFT_THREAD, `NUM_THREAD: architectural lanes per warp instruction.
- HARD_THREAD, 4: physical multiplier lanes, 1..SOFT_THREAD. Need not divide SOFT_THREAD.
- MUL_STAGES, 2: multiplier pipeline depth, ≥1.
- NPASS (derived), ceil(SOFT_THREAD/HARD_THREAD).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- in_valid_i / in_ready_o  in / out  1 / 1  issue handshake.
- in1_i, in2_i, in3_i  in  SOFT_THREAD*`XLEN  operands a, b, c; lane i is at bits [(i+1)*XLEN-1 -: XLEN].
- mask_i  in  SOFT_THREAD  active lanes.
- ctrl_alu_fn_i  in  6  operation select; only [2:0] is decoded.
- ctrl_reverse_i  in  1  swap a and b.
- ctrl_wid_i  in  `DEPTH_WARP  warp id.
- ctrl_reg_idxw_i  in  `REGIDX_WIDTH+`REGEXT_WIDTH  destination register.
- ctrl_wvd_i, ctrl_wxd_i  in  1  vector / scalar writeback.
- outx_valid_o / outx_ready_i  out / in  scalar result handshake.
- outx_wb_wxd_rd_o  out  `XLEN  lane-0 result.
- outx_wxd_o, outx_reg_idwx_o, outx_warp_id_o  out  1 / idx / wid  scalar writeback tags.
- outv_valid_o / outv_ready_i  out / in  vector result handshake.
- outv_wb_wxd_rd_o  out  SOFT_THREAD*`XLEN  vector result.
- outv_wvd_mask_o  out  SOFT_THREAD  lane mask.
- outv_wvd_o, outv_reg_idxw_o, outv_warp_id_o  out  1 / idx / wid  vector writeback tags.

## Operation
- On accept (in_valid_i & in_ready_o), latch all operands, the mask and the control fields.
- ctrl_reverse_i swaps in1 and in2 per lane at latch time.
- Operation decode on ctrl_alu_fn_i[2:0]:
  - 0 MUL: low XLEN bits of a*b.
  - 1 MULH: high XLEN bits, a and b both signed.
  - 2 MULHSU: high XLEN bits, a signed, b unsigned.
  - 3 MULHU: high XLEN bits, both unsigned.
  - 4 MACC: low XLEN bits of a*b + c.
  - 5 NMSAC: low XLEN bits of c − a*b.
  - 6, 7: treated as MUL.
  - All arithmetic is modulo 2^XLEN. The product is 2*XLEN bits wide.
- Routing: wxd has priority over wvd.
  - wxd set: one pass only (pass 0), using lane 0 regardless of mask; result goes to the outx port.
  - wxd clear, wvd set: result goes to the outv port.
  - Neither set: full computation runs, the result is discarded, and the block returns to IDLE without asserting any valid.
- Pass p covers lanes p*HARD_THREAD .. p*HARD_THREAD+HARD_THREAD-1. Lanes at or beyond SOFT_THREAD are padded with zero and ignored.
  - A vector pass is issued only if its slice of mask_i is non-zero.
  - Skipped passes, and masked-off lanes inside issued passes, write 0 into the result buffer.
- Per-lane commit: each in-flight pass carries its pass index down the pipeline. On exit, the result is written into that slice of the SOFT_THREAD-wide result buffer.
- FSM states:
  - IDLE: in_ready_o=1. Accept → ISSUE. If wvd-only and mask_i=0, go straight to OUT with a zero result.
  - ISSUE: issue the next active pass each cycle. After the last active pass → DRAIN.
  - DRAIN: wait until the last issued pass exits the pipeline → OUT. A silent op (neither wxd nor wvd) goes → IDLE instead.
  - OUT: assert the selected valid and hold data stable until ready → IDLE.
- There is no overlap between operations: in_ready_o=0 in every state except IDLE.

## Timing
- Reset value: every output is 0, including in_ready_o while rst_n is low. After rst_n deasserts, in_ready_o=1 and the FSM is in IDLE.
- Latency: valid rises exactly NI+MUL_STAGES cycles after the accept edge, where NI is the number of issued passes.
  - Zero-mask vector op: valid rises 1 cycle after accept.
- Backpressure: while valid is high and ready is low, all output data and tags are held unchanged.
- Completion: on a valid&ready edge the FSM returns to IDLE. The next accept can happen on the following edge, not the same one.
- Reset mid-operation: in-flight passes are aborted, outputs are cleared, and no stale valid appears afterwards.
- in_valid_i is ignored outside IDLE.

## Test plan
Configuration for all cases: SOFT_THREAD=8, HARD_THREAD=4, MUL_STAGES=2, XLEN=32.

- Vector MUL, mask=0xFF, in1=lane index i, in2=3 → outv_wb = {21,18,…,3,0}, mask 0xFF, outv_valid high 4 cycles after accept.
- Vector MACC, mask=0x0F, a=2, b=5, c=1 → lanes 0-3 = 11, lanes 4-7 = 0. Only one pass issued; valid at accept+3.
- MULH / MULHSU / MULHU with a=0xFFFFFFFF, b=2 → 0xFFFFFFFF, 0xFFFFFFFF, 0x00000001 respectively. Repeat MUL with ctrl_reverse_i=1 and a, b swapped → same result.
- Scalar NMSAC with wxd=1, wvd=1, c=10, a=3, b=4 → outx_wb=0xFFFFFFFE, outx_valid at accept+3, outv_valid stays 0.
- Vector op with mask=0, then an op with neither wxd nor wvd:
  - First → outv_valid at accept+1, data 0.
  - Second → no valid asserted, in_ready_o returns to 1 after MUL_STAGES+1 cycles.
- Hold outv_ready_i low for 5 cycles → data stable throughout and in_ready_o=0. Assert rst_n low mid-ISSUE → all outputs 0, and the next op completes correctly.
